// File: rtl/shifter_pipe_nb.sv
// shifter_pipe_nb: pipelined multi-mode barrel shifter with a valid/ready
// handshake between stages. There is one log-step per register, so the
// pipeline depth is SHW = $clog2(WIDTH). It accepts one operation per cycle.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   flush      synchronous kill of all in-flight operations
//   in_valid   input operation valid
//   in_ready   block can accept an operation this cycle (combinational)
//   a          operand
//   shamt      shift amount, 0..WIDTH-1
//   op         000 SLL, 001 SRL, 010 SRA, 011 ROR, 100 ROL, others pass a
//   out_valid  y is valid
//   out_ready  consumer accepts y
//   y          result
//   carry_out  last bit shifted out or wrapped, aligned with y
//              (present only when SHIFTER_PIPE_CARRY_EN is defined)
//
// Optional feature macro: SHIFTER_PIPE_CARRY_EN

module shifter_pipe_nb #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   shamt,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y
`ifdef SHIFTER_PIPE_CARRY_EN
    ,
    output logic             carry_out
`endif
);

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;

    // One log-step of the shift by s bits; reserved ops pass data through.
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       o,
        input logic             sg,
        input int unsigned      s
    );
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] fill;
        fill = sg ? ~({WIDTH{1'b1}} >> s) : '0;
        case (o)
            OP_SLL:  r = d << s;
            OP_SRL:  r = d >> s;
            OP_SRA:  r = (d >> s) | fill;
            OP_ROR:  r = (d >> s) | (d << (WIDTH - s));
            OP_ROL:  r = (d << s) | (d >> (WIDTH - s));
            default: r = d;
        endcase
        return r;
    endfunction

`ifdef SHIFTER_PIPE_CARRY_EN
    // Bit leaving (or wrapping out of) the word at this step. The last
    // active step wins, which yields the overall last bit shifted out.
    function automatic logic carry_step(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       o,
        input logic             cin,
        input int unsigned      s
    );
        logic [SHW-1:0] lo;
        logic [SHW-1:0] hi;
        logic           c;
        lo = SHW'(s - 1);
        hi = SHW'(WIDTH - s);
        case (o)
            OP_SLL, OP_ROL:         c = d[hi];
            OP_SRL, OP_SRA, OP_ROR: c = d[lo];
            default:                c = cin;
        endcase
        return c;
    endfunction
`endif

    // Stage registers
    logic [SHW-1:0]   vld_q;
    logic [WIDTH-1:0] data_q [SHW];
    logic [2:0]       op_q   [SHW];
    logic             sg_q   [SHW];
    logic [SHW-1:0]   sh_q   [SHW];   // remaining shamt bits, next one at bit 0
`ifdef SHIFTER_PIPE_CARRY_EN
    logic [SHW-1:0]   carry_q;
`endif

    // Stage inputs and next values
    logic [WIDTH-1:0] st_d  [SHW];
    logic [2:0]       st_op [SHW];
    logic [SHW-1:0]   st_sh [SHW];
    logic [SHW-1:0]   st_v;
    logic [SHW-1:0]   st_sg;
    logic [WIDTH-1:0] nx_d  [SHW];
`ifdef SHIFTER_PIPE_CARRY_EN
    logic [SHW-1:0]   st_c;
    logic [SHW-1:0]   nx_c;
`endif
    logic [SHW:0]     rdy;

    // Stage k input comes from the ports for k=0, else from stage k-1.
    always_comb begin
        st_d[0]  = a;
        st_v[0]  = in_valid;
        st_op[0] = op;
        st_sg[0] = a[WIDTH-1];
        st_sh[0] = shamt;
`ifdef SHIFTER_PIPE_CARRY_EN
        st_c[0]  = 1'b0;
`endif
        for (int k = 1; k < SHW; k++) begin
            st_d[k]  = data_q[k-1];
            st_v[k]  = vld_q[k-1];
            st_op[k] = op_q[k-1];
            st_sg[k] = sg_q[k-1];
            st_sh[k] = sh_q[k-1];
`ifdef SHIFTER_PIPE_CARRY_EN
            st_c[k]  = carry_q[k-1];
`endif
        end
    end

    // Stage k shifts by 2^k when its shamt bit is set.
    always_comb begin
        for (int k = 0; k < SHW; k++) begin
            nx_d[k] = st_sh[k][0] ? shift_step(st_d[k], st_op[k], st_sg[k], 32'd1 << k)
                                  : st_d[k];
`ifdef SHIFTER_PIPE_CARRY_EN
            nx_c[k] = st_sh[k][0] ? carry_step(st_d[k], st_op[k], st_c[k], 32'd1 << k)
                                  : st_c[k];
`endif
        end
    end

    // Ready chain: a stage can load when empty or when its successor can.
    always_comb begin
        rdy      = '0;
        rdy[SHW] = out_ready;
        for (int k = SHW - 1; k >= 0; k--) begin
            rdy[k] = ~vld_q[k] | rdy[k+1];
        end
    end

    assign in_ready = rdy[0] & ~flush;

    // Pipeline registers; flush kills only the valid bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            for (int k = 0; k < SHW; k++) begin
                data_q[k] <= '0;
                op_q[k]   <= '0;
                sg_q[k]   <= 1'b0;
                sh_q[k]   <= '0;
            end
`ifdef SHIFTER_PIPE_CARRY_EN
            carry_q <= '0;
`endif
        end else begin
            for (int k = 0; k < SHW; k++) begin
                if (flush) begin
                    vld_q[k] <= 1'b0;
                end else if (rdy[k]) begin
                    vld_q[k] <= st_v[k];
                end
                if (rdy[k]) begin
                    data_q[k] <= nx_d[k];
                    op_q[k]   <= st_op[k];
                    sg_q[k]   <= st_sg[k];
                    sh_q[k]   <= st_sh[k] >> 1;
`ifdef SHIFTER_PIPE_CARRY_EN
                    carry_q[k] <= nx_c[k];
`endif
                end
            end
        end
    end

    assign out_valid = vld_q[SHW-1];
    assign y         = data_q[SHW-1];
`ifdef SHIFTER_PIPE_CARRY_EN
    assign carry_out = carry_q[SHW-1];
`endif

endmodule
